downsampler_2x2: RTL and testbench

Averaging 2:1 decimator for the feature-detection pyramid: consumes a raster-order 8-bit pixel stream and emits one pixel per 2x2 input block, with the output's row and column coordinates. It sits directly upstream of the upsampling stage. Its output stream (`dataout`/`validout`) drives the write side of that stage's clock-crossing FIFO (`din`/`wr_en`). No backpressure: the downstream FIFO is sized to absorb a full output line.

---
 rtl/downsampler_2x2_if.sv | 34 +++
 rtl/downsampler_2x2.sv | 145 ++++++++++++++
 tb/tb_downsampler_2x2.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/downsampler_2x2_if.sv
// Pixel-stream interface for the 2x2 averaging decimator: raster input side
// (din/valid/sync) and decimated output side with block coordinates.
interface downsampler_2x2_if;
    logic [7:0] din;
    logic       valid;
    logic       sync;
    logic [7:0] dataout;
    logic       validout;
    logic [9:0] rownum;
    logic [9:0] colnum;
    logic       frame_done;

    modport slave (
        input  din,
        input  valid,
        input  sync,
        output dataout,
        output validout,
        output rownum,
        output colnum,
        output frame_done
    );

    modport master (
        output din,
        output valid,
        output sync,
        input  dataout,
        input  validout,
        input  rownum,
        input  colnum,
        input  frame_done
    );
endinterface

// File: rtl/downsampler_2x2.sv
// Averaging 2:1 decimator: one round-half-up mean per 2x2 raster block, with
// even-row pair sums parked in a half-width line buffer until the odd row.
module downsampler_2x2 #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic              clock,
    input  logic              reset,
    downsampler_2x2_if.slave  stream
);

    localparam int LB_DEPTH = WIDTH / 2;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [9:0] LAST_COL = 10'(WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(HEIGHT - 1);

    function automatic logic [7:0] round_quarter(input logic [9:0] sum);
        logic [9:0] biased;
        biased = sum + 10'd2;
        return biased[9:2];
    endfunction

    logic [9:0]    in_col_q, in_col_d;
    logic [9:0]    in_row_q, in_row_d;
    logic [7:0]    h_q, h_d;
    logic [8:0]    lb_rd_q;
    logic [7:0]    dataout_q, dataout_d;
    logic          validout_q, validout_d;
    logic [9:0]    rownum_q, rownum_d;
    logic [9:0]    colnum_q, colnum_d;
    logic          frame_done_q, frame_done_d;

    logic [9:0]    pos_col_s;
    logic [9:0]    pos_row_s;
    logic [AW-1:0] lb_addr_s;
    logic [8:0]    lb_wdata_s;
    logic [9:0]    sum_s;
    logic          lb_we_s;
    logic          lb_re_s;

    logic [8:0]    lb_mem [LB_DEPTH];

    // Position of the current pixel: a qualified sync pins it to the frame origin.
    always_comb begin
        pos_col_s = in_col_q;
        pos_row_s = in_row_q;
        if (stream.valid && stream.sync) begin
            pos_col_s = 10'd0;
            pos_row_s = 10'd0;
        end else begin
            pos_col_s = in_col_q;
            pos_row_s = in_row_q;
        end
    end

    assign lb_addr_s  = pos_col_s[AW:1];
    assign lb_wdata_s = {1'b0, h_q} + {1'b0, stream.din};
    assign sum_s      = {1'b0, lb_rd_q} + {2'b00, h_q} + {2'b00, stream.din};

    // Counter advance, block accumulation and output update for an accepted pixel.
    always_comb begin
        in_col_d     = in_col_q;
        in_row_d     = in_row_q;
        h_d          = h_q;
        dataout_d    = dataout_q;
        rownum_d     = rownum_q;
        colnum_d     = colnum_q;
        validout_d   = 1'b0;
        frame_done_d = 1'b0;
        lb_we_s      = 1'b0;
        lb_re_s      = 1'b0;
        if (stream.valid) begin
            if (pos_col_s == LAST_COL) begin
                in_col_d = 10'd0;
                if (pos_row_s == LAST_ROW) begin
                    in_row_d = 10'd0;
                end else begin
                    in_row_d = pos_row_s + 10'd1;
                end
            end else begin
                in_col_d = pos_col_s + 10'd1;
                in_row_d = pos_row_s;
            end
            case ({pos_row_s[0], pos_col_s[0]})
                2'b00: h_d = stream.din;
                2'b01: lb_we_s = 1'b1;
                2'b10: begin
                    h_d     = stream.din;
                    lb_re_s = 1'b1;
                end
                2'b11: begin
                    dataout_d    = round_quarter(sum_s);
                    rownum_d     = {1'b0, pos_row_s[9:1]};
                    colnum_d     = {1'b0, pos_col_s[9:1]};
                    validout_d   = 1'b1;
                    frame_done_d = (pos_row_s == LAST_ROW) && (pos_col_s == LAST_COL);
                end
                default: h_d = h_q;
            endcase
        end else begin
            in_col_d = in_col_q;
        end
    end

    // Line buffer storage; contents need no reset since every entry is rewritten before use.
    always_ff @(posedge clock) begin
        if (lb_we_s) begin
            lb_mem[lb_addr_s] <= lb_wdata_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_col_q     <= 10'd0;
            in_row_q     <= 10'd0;
            h_q          <= 8'd0;
            lb_rd_q      <= 9'd0;
            dataout_q    <= 8'd0;
            validout_q   <= 1'b0;
            rownum_q     <= 10'd0;
            colnum_q     <= 10'd0;
            frame_done_q <= 1'b0;
        end else begin
            in_col_q     <= in_col_d;
            in_row_q     <= in_row_d;
            h_q          <= h_d;
            if (lb_re_s) begin
                lb_rd_q <= lb_mem[lb_addr_s];
            end
            dataout_q    <= dataout_d;
            validout_q   <= validout_d;
            rownum_q     <= rownum_d;
            colnum_q     <= colnum_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign stream.dataout    = dataout_q;
    assign stream.validout   = validout_q;
    assign stream.rownum     = rownum_q;
    assign stream.colnum     = colnum_q;
    assign stream.frame_done = frame_done_q;

endmodule

// File: tb/tb_downsampler_2x2.sv
// Directed bench for downsampler_2x2 on an 8x4 frame: a frame-array model predicts
// every output cycle, plus literal checks on selected results.
module tb_downsampler_2x2;

    localparam int W = 8;
    localparam int H = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic cmp_en = 1'b0;

    downsampler_2x2_if dif ();

    downsampler_2x2 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock  (clock),
        .reset  (reset),
        .stream (dif)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // model state: whole-frame pixel array plus raster position
    int pix [H][W];
    int mr, mc;
    int ev, ed, er, ec, ef;

    int gd[$];
    int gr[$];
    int gc[$];
    int n_fd;

    int rnd [32] = '{1, 2, 1, 1, 255, 255, 0, 0,
                     3, 4, 1, 2, 255, 255, 0, 2,
                     0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mr = 0; mc = 0;
        ev = 0; ed = 0; er = 0; ec = 0; ef = 0;
    endtask

    task automatic model_accept(input int d, input bit s);
        int sum;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        pix[mr][mc] = d;
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            sum = pix[mr-1][mc-1] + pix[mr-1][mc] + pix[mr][mc-1] + pix[mr][mc];
            ev = 1;
            ed = (sum + 2) / 4;
            er = mr / 2;
            ec = mc / 2;
            ef = (mr == H - 1 && mc == W - 1) ? 1 : 0;
        end else begin
            ev = 0;
            ef = 0;
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    // called at a negedge; returns at the following negedge
    task automatic drive(input int d, input bit s);
        dif.din   = d[7:0];
        dif.valid = 1'b1;
        dif.sync  = s;
        @(posedge clock);
        model_accept(d, s);
        @(negedge clock);
        dif.valid = 1'b0;
        dif.sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            dif.din  = 8'($urandom_range(0, 255));
            dif.sync = 1'($urandom_range(0, 1));
            @(posedge clock);
            ev = 0;
            ef = 0;
            @(negedge clock);
        end
        dif.sync = 1'b0;
    endtask

    task automatic clear_capture();
        gd.delete();
        gr.delete();
        gc.delete();
        n_fd = 0;
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("validout", int'(dif.validout), ev);
            chk("dataout", int'(dif.dataout), ed);
            chk("rownum", int'(dif.rownum), er);
            chk("colnum", int'(dif.colnum), ec);
            chk("frame_done", int'(dif.frame_done), ef);
            if (dif.validout === 1'b1) begin
                gd.push_back(int'(dif.dataout));
                gr.push_back(int'(dif.rownum));
                gc.push_back(int'(dif.colnum));
            end
            if (dif.frame_done === 1'b1) n_fd++;
        end
    end

    initial begin
        dif.din = 8'd0;
        dif.valid = 1'b0;
        dif.sync = 1'b0;
        model_reset();
        clear_capture();
        repeat (3) @(negedge clock);
        chk("rst_validout", int'(dif.validout), 0);
        chk("rst_dataout", int'(dif.dataout), 0);
        chk("rst_rownum", int'(dif.rownum), 0);
        chk("rst_colnum", int'(dif.colnum), 0);
        chk("rst_frame_done", int'(dif.frame_done), 0);
        reset = 1'b1;
        cmp_en = 1'b1;
        @(negedge clock);

        // constant frame
        clear_capture();
        for (int i = 0; i < 32; i++) drive(100, i == 0);
        idle(2);
        chk("const_count", gd.size(), 8);
        chk("const_fd", n_fd, 1);
        if (gd.size() == 8) begin
            chk("const_first_val", gd[0], 100);
            chk("const_first_row", gr[0], 0);
            chk("const_first_col", gc[0], 0);
            chk("const_last_row", gr[7], 1);
            chk("const_last_col", gc[7], 3);
        end

        // rounding blocks
        clear_capture();
        for (int i = 0; i < 32; i++) drive(rnd[i], i == 0);
        idle(2);
        chk("round_count", gd.size(), 8);
        if (gd.size() == 8) begin
            chk("round_1234", gd[0], 3);
            chk("round_1112", gd[1], 1);
            chk("round_255", gd[2], 255);
            chk("round_0002", gd[3], 1);
        end

        // gapped constant frame
        clear_capture();
        for (int i = 0; i < 32; i++) begin
            drive(100, i == 0);
            idle($urandom_range(0, 2));
        end
        idle(2);
        chk("gap_count", gd.size(), 8);
        chk("gap_fd", n_fd, 1);
        for (int k = 0; k < gd.size() && k < 8; k++) begin
            chk("gap_val", gd[k], 100);
            chk("gap_row", gr[k], k / 4);
            chk("gap_col", gc[k], k % 4);
        end

        // mid-frame sync at input (row 2, col 5)
        clear_capture();
        for (int i = 0; i < 21; i++) drive(i, i == 0);
        drive(21, 1'b1);
        for (int i = 1; i < 32; i++) drive(i, 1'b0);
        idle(2);
        chk("sync_count", gd.size(), 12);
        chk("sync_fd", n_fd, 1);
        if (gd.size() == 12) begin
            chk("sync_first_val", gd[4], 10);
            chk("sync_first_row", gr[4], 0);
            chk("sync_first_col", gc[4], 0);
            chk("sync_second_val", gd[5], 7);
        end

        // reset mid-frame after input (row 1, col 2)
        for (int i = 0; i < 11; i++) drive(i, i == 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_dataout", int'(dif.dataout), 0);
        chk("arst_validout", int'(dif.validout), 0);
        chk("arst_rownum", int'(dif.rownum), 0);
        chk("arst_colnum", int'(dif.colnum), 0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        clear_capture();
        for (int i = 0; i < 32; i++) drive(i, 1'b0);
        idle(2);
        chk("rst_frame_count", gd.size(), 8);
        chk("rst_frame_fd", n_fd, 1);
        if (gd.size() == 8) begin
            chk("rst_frame_first", gd[0], 5);
            chk("rst_frame_last", gd[7], 27);
        end

        // back-to-back frames
        clear_capture();
        for (int i = 0; i < 64; i++) drive((i < 32) ? 10 : 200, (i % 32) == 0);
        idle(2);
        chk("b2b_count", gd.size(), 16);
        chk("b2b_fd", n_fd, 2);
        for (int k = 0; k < gd.size() && k < 16; k++) begin
            chk("b2b_val", gd[k], (k < 8) ? 10 : 200);
        end
        if (gd.size() == 16) begin
            chk("b2b_restart_row", gr[8], 0);
            chk("b2b_restart_col", gc[8], 0);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
